// File: rtl/svm_decision_engine_if.sv
// Support-vector stream: one feature element per beat, alpha_y rides the last beat.
// The master drives the stream and the engine (slave) returns ready.
interface svm_decision_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sv_valid;
  logic                  sv_ready;
  logic [DATA_WIDTH-1:0] sv_elem;
  logic [DATA_WIDTH-1:0] alpha_y;

  modport master (
    output sv_valid, sv_elem, alpha_y,
    input  sv_ready
  );

  modport slave (
    input  sv_valid, sv_elem, alpha_y,
    output sv_ready
  );
endinterface

// File: rtl/svm_decision_engine.sv
// Sequential linear-kernel SVM decision engine with a streamed support-vector input.
// Define SVM_DECISION_SAT_EN to saturate narrowing instead of wrapping.
module svm_decision_engine #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int FRAC_BITS    = 16,
  parameter  int FEATURE_SIZE = 13,
  parameter  int MAX_SV       = 16384,
  parameter  int ACC_WIDTH    = 96,
  localparam int SV_CNT_W     = $clog2(MAX_SV+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [FEATURE_SIZE*DATA_WIDTH-1:0] x_in,
  input  logic [SV_CNT_W-1:0]              num_sv,
  input  logic [DATA_WIDTH-1:0]            bias,
  svm_decision_engine_if.slave             sv_if,
  output logic                             busy,
  output logic                             result_valid,
  output logic [DATA_WIDTH-1:0]            decision_value,
  output logic                             classification_result,
  output logic                             overflow
);

  localparam int PW   = 2*DATA_WIDTH;
  localparam int FI_W = FEATURE_SIZE > 1 ? $clog2(FEATURE_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE, DOT, SCALE, ACC, FINAL, DONE
  } state_t;

  state_t state_q, state_d;

  logic [FEATURE_SIZE*DATA_WIDTH-1:0] x_q;
  logic [SV_CNT_W-1:0]                num_q;
  logic [SV_CNT_W-1:0]                cnt_q;
  logic [FI_W-1:0]                    feat_q;
  logic signed [DATA_WIDTH-1:0]       bias_q;
  logic signed [DATA_WIDTH-1:0]       alpha_q;
  logic signed [ACC_WIDTH-1:0]        dot_acc;
  logic signed [ACC_WIDTH-1:0]        dec_acc;
  logic signed [ACC_WIDTH-1:0]        term_q;
  logic                               ovf_q;

  logic [SV_CNT_W-1:0]          num_eff;
  logic                         fire;
  logic                         last_feat;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  k_full;
  logic signed [DATA_WIDTH-1:0] kernel;
  logic signed [PW-1:0]         kprod;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0]        sum_n;

  // A value fits iff every bit above the target sign bit matches it.
  function automatic logic ovf_of(
    input logic signed [ACC_WIDTH-1:0] v
  );
    return !((&v[ACC_WIDTH-1:DATA_WIDTH-1]) ||
             !(|v[ACC_WIDTH-1:DATA_WIDTH-1]));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] narrow(
    input logic signed [ACC_WIDTH-1:0] v
  );
`ifdef SVM_DECISION_SAT_EN
    if (ovf_of(v))
      return v[ACC_WIDTH-1] ?
        {1'b1, {(DATA_WIDTH-1){1'b0}}} :
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      return v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  assign num_eff = (num_sv > SV_CNT_W'(MAX_SV)) ?
                   SV_CNT_W'(MAX_SV) : num_sv;

  assign sv_if.sv_ready = (state_q == DOT);
  assign busy           = (state_q != IDLE);
  assign result_valid   = (state_q == DONE);

  assign fire      = sv_if.sv_valid && (state_q == DOT);
  assign last_feat = (feat_q == FI_W'(FEATURE_SIZE-1));
  assign x_cur     = x_q[feat_q*DATA_WIDTH +: DATA_WIDTH];
  assign prod      = PW'(x_cur) * PW'($signed(sv_if.sv_elem));
  assign k_full    = dot_acc >>> FRAC_BITS;
  assign kernel    = narrow(k_full);
  assign kprod     = PW'(kernel) * PW'(alpha_q);
  assign sum       = dec_acc + ACC_WIDTH'(bias_q);
  assign sum_n     = narrow(sum);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start)
               state_d = (num_eff == '0) ? FINAL : DOT;
      DOT:   if (fire && last_feat)
               state_d = SCALE;
      SCALE: state_d = ACC;
      ACC:   state_d = (cnt_q + SV_CNT_W'(1) == num_q) ?
                       FINAL : DOT;
      FINAL: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q                   <= '0;
      num_q                 <= '0;
      cnt_q                 <= '0;
      feat_q                <= '0;
      bias_q                <= '0;
      alpha_q               <= '0;
      dot_acc               <= '0;
      dec_acc               <= '0;
      term_q                <= '0;
      ovf_q                 <= 1'b0;
      decision_value        <= '0;
      classification_result <= 1'b0;
      overflow              <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          x_q     <= x_in;
          num_q   <= num_eff;
          bias_q  <= $signed(bias);
          dot_acc <= '0;
          dec_acc <= '0;
          feat_q  <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
        DOT: if (fire) begin
          dot_acc <= dot_acc + ACC_WIDTH'(prod);
          if (last_feat) begin
            feat_q  <= '0;
            alpha_q <= $signed(sv_if.alpha_y);
          end else begin
            feat_q <= feat_q + FI_W'(1);
          end
        end
        SCALE: begin
          term_q <= ACC_WIDTH'(kprod >>> FRAC_BITS);
          if (ovf_of(k_full)) ovf_q <= 1'b1;
        end
        ACC: begin
          dec_acc <= dec_acc + term_q;
          dot_acc <= '0;
          cnt_q   <= cnt_q + SV_CNT_W'(1);
        end
        FINAL: begin
          decision_value        <= sum_n;
          classification_result <= !sum_n[DATA_WIDTH-1] && (|sum_n);
          overflow              <= ovf_q | ovf_of(sum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_decision_engine.sv
// Self-checking bench for svm_decision_engine: directed cases plus
// randomized vectors against an arithmetic reference model.
module tb_svm_decision_engine;
  localparam int DW  = 32;
  localparam int FS  = 13;
  localparam int MSV = 16384;
  localparam int SCW = $clog2(MSV+1);
  localparam int NSV = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [FS*DW-1:0] x_in;
  logic [SCW-1:0] num_sv;
  logic [DW-1:0]  bias;
  logic           busy;
  logic           result_valid;
  logic [DW-1:0]  decision_value;
  logic           classification_result;
  logic           overflow;

  svm_decision_engine_if #(.DATA_WIDTH(DW)) sv_if ();

  svm_decision_engine dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .x_in                  (x_in),
    .num_sv                (num_sv),
    .bias                  (bias),
    .sv_if                 (sv_if),
    .busy                  (busy),
    .result_valid          (result_valid),
    .decision_value        (decision_value),
    .classification_result (classification_result),
    .overflow              (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] xv  [FS];
  logic [DW-1:0] svm [NSV][FS];
  logic [DW-1:0] av  [NSV];

  int            lat;
  int            beats;
  int            idle_ready;
  bit            saw_ready;
  logic [DW-1:0] r_dv;
  logic          r_cls;
  logic          r_ovf;

  function automatic logic [DW:0] narrow_m(input logic signed [127:0] v);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = 128'sh7FFF_FFFF;
    lo = -128'sh8000_0000;
    if (v > hi || v < lo) begin
`ifdef SVM_DECISION_SAT_EN
      return {1'b1, (v > hi) ? 32'h7FFF_FFFF : 32'h8000_0000};
`else
      return {1'b1, v[DW-1:0]};
`endif
    end
    return {1'b0, v[DW-1:0]};
  endfunction

  task automatic model(input int n, input logic [DW-1:0] b,
                       output logic [DW-1:0] dv, output bit cls, output bit ovf);
    logic signed [127:0] dot, acc, t;
    logic [DW:0] r;
    acc = 0;
    ovf = 0;
    for (int s = 0; s < n; s++) begin
      dot = 0;
      for (int f = 0; f < FS; f++)
        dot += 128'($signed(xv[f])) * 128'($signed(svm[s][f]));
      r = narrow_m(dot >>> 16);
      ovf |= r[DW];
      t = 128'($signed(r[DW-1:0])) * 128'($signed(av[s]));
      acc += t >>> 16;
    end
    r = narrow_m(acc + 128'($signed(b)));
    ovf |= r[DW];
    dv = r[DW-1:0];
    cls = ($signed(dv) > 0);
  endtask

  task automatic fill_unit();
    for (int f = 0; f < FS; f++) xv[f] = 32'h0001_0000;
    for (int s = 0; s < NSV; s++) begin
      av[s] = 32'h0001_0000;
      for (int f = 0; f < FS; f++) svm[s][f] = 32'h0001_0000;
    end
  endtask

  task automatic run(input int n, input logic [DW-1:0] b,
                     input int stall_at, input int stall_len, input bit rnd);
    int si, f, c, stalled;
    si = 0; f = 0; stalled = 0;
    for (int i = 0; i < FS; i++) x_in[i*DW +: DW] = xv[i];
    num_sv = SCW'(n);
    bias = b;
    saw_ready = 0; beats = 0; idle_ready = 0; lat = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (lat < 0) begin
      if (result_valid) begin
        lat = c;
        r_dv = decision_value;
        r_cls = classification_result;
        r_ovf = overflow;
      end else if (c > 3000) begin
        $display("FAIL run_timeout: no result_valid after %0d cycles, required one", c);
        lat = -2;
      end else begin
        if (sv_if.sv_ready) saw_ready = 1;
        sv_if.sv_valid = 1'b1;
        if (beats == stall_at && stalled < stall_len) begin
          sv_if.sv_valid = 1'b0;
          stalled++;
        end
        if (rnd && $urandom_range(0, 3) == 0) sv_if.sv_valid = 1'b0;
        sv_if.sv_elem = (si < NSV) ? svm[si][f] : '0;
        sv_if.alpha_y = (si < NSV) ? av[si] : '0;
        if (sv_if.sv_ready && !sv_if.sv_valid) idle_ready++;
        if (sv_if.sv_valid && sv_if.sv_ready) begin
          beats++;
          if (f == FS-1) begin f = 0; si++; end
          else f++;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    sv_if.sv_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (sv_if.sv_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", sv_if.sv_ready); end
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
    n_tests++; if (decision_value !== '0) begin n_fail++; $display("FAIL reset_dv got=%h exp=0", decision_value); end
    n_tests++; if ({classification_result, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_cls_ovf got=%b%b exp=00", classification_result, overflow); end
  endtask

  task automatic test_basic();
    fill_unit();
    run(1, 32'hFFFA_0000, -1, 0, 0);
    n_tests++; if (lat != 17) begin n_fail++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    n_tests++; if (r_dv !== 32'h0007_0000) begin n_fail++; $display("FAIL basic_dv got=%h exp=00070000", r_dv); end
    n_tests++; if ({r_cls, r_ovf} !== 2'b10) begin n_fail++; $display("FAIL basic_cls_ovf got=%b%b exp=10", r_cls, r_ovf); end
    @(posedge clk); #1;
    n_tests++; if ({result_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse got=%b%b exp=00", result_valid, busy); end
    n_tests++; if (decision_value !== 32'h0007_0000) begin n_fail++; $display("FAIL basic_hold got=%h exp=00070000", decision_value); end
  endtask

  task automatic test_zero_sv();
    fill_unit();
    run(0, 32'hFFFA_0000, -1, 0, 0);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    n_tests++; if (r_dv !== 32'hFFFA_0000) begin n_fail++; $display("FAIL zero_dv got=%h exp=fffa0000", r_dv); end
    n_tests++; if (r_cls !== 1'b0) begin n_fail++; $display("FAIL zero_cls got=%b exp=0", r_cls); end
    n_tests++; if (saw_ready) begin n_fail++; $display("FAIL zero_ready got=1 exp=0"); end
  endtask

  task automatic test_strict_zero();
    fill_unit();
    for (int f = 6; f < FS; f++) svm[0][f] = '0;
    run(1, 32'hFFFA_0000, -1, 0, 0);
    n_tests++; if (r_dv !== 32'h0) begin n_fail++; $display("FAIL strict_dv got=%h exp=00000000", r_dv); end
    n_tests++; if (r_cls !== 1'b0) begin n_fail++; $display("FAIL strict_cls got=%b exp=0", r_cls); end
  endtask

  task automatic test_stall();
    fill_unit();
    run(2, 32'hFFFA_0000, 6, 5, 0);
    n_tests++; if (lat != 37) begin n_fail++; $display("FAIL stall_latency got=%0d exp=37", lat); end
    n_tests++; if (r_dv !== 32'h0014_0000) begin n_fail++; $display("FAIL stall_dv got=%h exp=00140000", r_dv); end
    n_tests++; if (beats != 26) begin n_fail++; $display("FAIL stall_beats got=%0d exp=26", beats); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_dv;
`ifdef SVM_DECISION_SAT_EN
    exp_dv = 32'h7FFF_FFFF;
`else
    exp_dv = 32'h000D_0000;
`endif
    fill_unit();
    for (int f = 0; f < FS; f++) begin
      xv[f] = 32'h7FFF_0000;
      svm[0][f] = 32'h7FFF_0000;
    end
    run(1, 32'h0, -1, 0, 0);
    n_tests++; if (r_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", r_ovf); end
    n_tests++; if (r_dv !== exp_dv) begin n_fail++; $display("FAIL ovf_dv got=%h exp=%h", r_dv, exp_dv); end
    n_tests++; if (r_cls !== 1'b1) begin n_fail++; $display("FAIL ovf_cls got=%b exp=1", r_cls); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    fill_unit();
    for (int i = 0; i < FS; i++) x_in[i*DW +: DW] = xv[i];
    num_sv = SCW'(1);
    bias = 32'hFFFA_0000;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sv_if.sv_valid = 1'b1;
    sv_if.sv_elem = 32'h0001_0000;
    sv_if.alpha_y = 32'h0001_0000;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if ({busy, sv_if.sv_ready} !== 2'b11) begin n_fail++; $display("FAIL abort_in_dot got=%b%b exp=11", busy, sv_if.sv_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if ({busy, sv_if.sv_ready, result_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_ctrl got=%b%b%b exp=000", busy, sv_if.sv_ready, result_valid); end
    n_tests++; if ({decision_value, classification_result, overflow} !== '0) begin n_fail++; $display("FAIL abort_outputs got=%h %b %b exp=0 0 0", decision_value, classification_result, overflow); end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_no_result got=1 exp=0"); end
    sv_if.sv_valid = 1'b0;
    test_basic();
  endtask

  task automatic test_back_to_back();
    int hits[$];
    num_sv = '0;
    bias = 32'h0003_0000;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (result_valid) hits.push_back(c);
    end
    start = 1'b0;
    n_tests++; if (hits.size() != 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", hits.size()); end
    n_tests++; if (hits.size() < 2 || hits[1] - hits[0] != 3) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=3", hits.size() < 2 ? -1 : hits[1] - hits[0]); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [DW-1:0] e_dv;
    logic [DW-1:0] b;
    bit e_cls, e_ovf, big;
    int n;
    for (int it = 0; it < 6; it++) begin
      big = (it == 5);
      n = $urandom_range(1, 4);
      for (int f = 0; f < FS; f++)
        xv[f] = big ? $urandom : DW'($urandom_range(0, 32'h0008_0000) - 32'h0004_0000);
      for (int s = 0; s < NSV; s++) begin
        av[s] = big ? $urandom : DW'($urandom_range(0, 32'h0008_0000) - 32'h0004_0000);
        for (int f = 0; f < FS; f++)
          svm[s][f] = big ? $urandom : DW'($urandom_range(0, 32'h0008_0000) - 32'h0004_0000);
      end
      b = DW'($urandom_range(0, 32'h0010_0000) - 32'h0008_0000);
      model(n, b, e_dv, e_cls, e_ovf);
      run(n, b, -1, 0, 1);
      n_tests++; if (r_dv !== e_dv) begin n_fail++; $display("FAIL rand%0d_dv got=%h exp=%h", it, r_dv, e_dv); end
      n_tests++; if ({r_cls, r_ovf} !== {e_cls, e_ovf}) begin n_fail++; $display("FAIL rand%0d_cls_ovf got=%b%b exp=%b%b", it, r_cls, r_ovf, e_cls, e_ovf); end
      n_tests++; if (lat != n*(FS+2) + 2 + idle_ready) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, n*(FS+2) + 2 + idle_ready); end
      n_tests++; if (beats != n*FS) begin n_fail++; $display("FAIL rand%0d_beats got=%0d exp=%0d", it, beats, n*FS); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    x_in = '0;
    num_sv = '0;
    bias = '0;
    sv_if.sv_valid = 1'b0;
    sv_if.sv_elem = '0;
    sv_if.alpha_y = '0;
    test_reset();
    test_basic();
    test_zero_sv();
    test_strict_zero();
    test_stall();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_decision_engine.md
# svm_decision_engine

Parametrised, sequential SVM decision engine for the classifier datapath. It latches one input feature vector on `start`, then consumes a stream of support vectors over a valid/ready handshake, one feature element per beat. For each support vector it forms the linear-kernel dot product and accumulates `alpha_y * kernel` in a wide accumulator. After the last support vector it adds the bias and delivers a signed decision value, a class bit and an overflow flag.

## Interface
- `DATA_WIDTH`, 32: width of every fixed-point operand; signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- `FRAC_BITS`, 16: fractional bits of all operands and results.
- `FEATURE_SIZE`, 13: features per vector (≥1).
- `MAX_SV`, 16384: maximum support vectors per classification.
- `ACC_WIDTH`, 96: signed width of the dot-product and decision accumulators (≥ 2*DATA_WIDTH + $clog2(MAX_SV*FEATURE_SIZE)).
- Localparam `SV_CNT_W` = $clog2(MAX_SV+1).
- Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a classification; sampled only in IDLE.
- `x_in`  in  FEATURE_SIZE*DATA_WIDTH  input vector; feature i is at `[i*DATA_WIDTH +: DATA_WIDTH]`; latched when start is accepted.
- `num_sv`  in  SV_CNT_W  support-vector count; latched with start; values > MAX_SV clamp to MAX_SV.
- `bias`  in  DATA_WIDTH  signed bias; latched with start.
- `sv_valid`  in  1  stream beat valid.
- `sv_ready`  out  1  engine accepts a beat.
- `sv_elem`  in  DATA_WIDTH  support-vector feature element; features arrive in index order 0..FEATURE_SIZE-1.
- `alpha_y`  in  DATA_WIDTH  signed alpha·label; sampled only on the beat carrying feature FEATURE_SIZE-1.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse when a result is ready.
- `decision_value`  out  DATA_WIDTH  signed decision value; holds until the next result.
- `classification_result`  out  1  1 iff decision_value > 0, compared as signed.
- `overflow`  out  1  any narrowing in this classification exceeded range; held with the result.

## Operation
- FSM states: IDLE, DOT, SCALE, ACC, FINAL, DONE.
- IDLE:
  - On `start`: latch x_in, num_sv and bias; clear both accumulators, the feature index, the SV counter and the overflow flag.
  - Go to FINAL if num_sv==0, else to DOT.
- DOT:
  - `sv_ready`=1. A beat transfers when sv_valid && sv_ready.
  - Each beat adds the full-precision product `x[f]*sv_elem` (2*DATA_WIDTH, signed) into the dot accumulator.
  - On the beat with f==FEATURE_SIZE-1, latch alpha_y and go to SCALE.
- SCALE:
  - kernel = dot_acc >>> FRAC_BITS (arithmetic shift), narrowed to DATA_WIDTH.
  - term = (kernel*alpha_y) >>> FRAC_BITS, sign-extended to ACC_WIDTH.
- ACC:
  - decision_acc += term; clear dot_acc; increment the SV counter.
  - Go to FINAL when count==num_sv, else to DOT.
- FINAL: sum = decision_acc + sign-extended bias, narrowed to DATA_WIDTH and registered into decision_value and classification_result.
- DONE: result_valid=1 for this cycle; return to IDLE.
- Narrowing: if the value lies outside the signed DATA_WIDTH range, `overflow` is set. The resulting value depends on the configuration macro (see Configuration).
- `sv_ready`=0 outside DOT. Beats presented outside DOT are not consumed.
- `start` is ignored while busy.

## Timing
- Reset values: sv_ready=0, busy=0, result_valid=0, decision_value=0, classification_result=0, overflow=0; FSM in IDLE; accumulators and counters cleared.
- Reset asserted in any state aborts the classification on the next edge; no result_valid is produced.
- Start accepted at cycle T, with sv_valid held high: result_valid is high at cycle T + num_sv*(FEATURE_SIZE+2) + 2.
- Every cycle in DOT with sv_valid=0 adds exactly one cycle of latency. No data is lost or duplicated.
- A start in the same cycle as DONE is ignored. The earliest new start is the cycle after DONE.
- decision_value, classification_result and overflow change only in the cycle FINAL registers them.

## Configuration
- `SVM_DECISION_SAT_EN` defined: narrowing of kernel and decision saturates to 0x7FF..F / 0x800..0.
- Undefined: narrowing truncates to the low DATA_WIDTH bits (wraps).
- `overflow` is reported identically in both cases.

## Test plan
Defaults apply unless stated (FEATURE_SIZE=13, FRAC_BITS=16).
1. x=all 0x00010000, sv=all 0x00010000, alpha 0x00010000, num_sv=1, bias 0xFFFA0000 -> decision_value 0x00070000, class 1, overflow 0, result_valid at T+17.
2. num_sv=0, bias 0xFFFA0000 -> decision_value 0xFFFA0000, class 0, result_valid at T+2, sv_ready never high.
3. As test 1 but sv features 6..12 = 0 -> decision_value 0x00000000, class 0 (strict > 0).
4. As test 1, num_sv=2, with sv_valid deasserted for 5 cycles mid-vector -> decision_value 0x00140000, result_valid at T+32+5, beats not duplicated.
5. x=sv=all 0x7FFF0000, alpha 0x00010000, num_sv=1, bias 0 -> overflow 1. With SAT_EN: decision 0x7FFFFFFF, class 1. Without SAT_EN: wrapped low 32 bits of the full-precision result.
6. Assert rst during DOT of test 1 -> all outputs return to reset values, no result_valid. Rerunning test 1 then matches test 1 exactly.
